// File: rtl/mod_mult_arbiter_if.sv
// Bundle of client, multiplier and response handshake buses for mod_mult_arbiter.
// Handshake rule on every bus: a beat moves when val and rdy are both high at a rising edge; the sender holds its data until then.
interface mod_mult_arbiter_if #(
    parameter int NUM_CH   = 2,
    parameter int DAT_BITS = 256,
    parameter int CTL_BITS = 16
);
    localparam int TAG_BITS = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*2*DAT_BITS-1:0]  i_req_dat;
    logic [NUM_CH*CTL_BITS-1:0]    i_req_ctl;
    logic [NUM_CH-1:0]             i_req_err;
    logic [NUM_CH-1:0]             i_req_val;
    logic [NUM_CH-1:0]             o_req_rdy;

    logic [2*DAT_BITS-1:0]         o_mul_dat;
    logic [CTL_BITS+TAG_BITS-1:0]  o_mul_ctl;
    logic                          o_mul_err;
    logic                          o_mul_val;
    logic                          i_mul_rdy;

    logic [DAT_BITS-1:0]           i_res_dat;
    logic [CTL_BITS+TAG_BITS-1:0]  i_res_ctl;
    logic                          i_res_err;
    logic                          i_res_val;
    logic                          o_res_rdy;

    logic [NUM_CH*DAT_BITS-1:0]    o_rsp_dat;
    logic [NUM_CH*CTL_BITS-1:0]    o_rsp_ctl;
    logic [NUM_CH-1:0]             o_rsp_err;
    logic [NUM_CH-1:0]             o_rsp_val;
    logic [NUM_CH-1:0]             i_rsp_rdy;

    logic                          o_tag_err;

    modport slave (
        input  i_req_dat, i_req_ctl, i_req_err, i_req_val,
        output o_req_rdy,
        output o_mul_dat, o_mul_ctl, o_mul_err, o_mul_val,
        input  i_mul_rdy,
        input  i_res_dat, i_res_ctl, i_res_err, i_res_val,
        output o_res_rdy,
        output o_rsp_dat, o_rsp_ctl, o_rsp_err, o_rsp_val,
        input  i_rsp_rdy,
        output o_tag_err
    );

    modport master (
        output i_req_dat, i_req_ctl, i_req_err, i_req_val,
        input  o_req_rdy,
        input  o_mul_dat, o_mul_ctl, o_mul_err, o_mul_val,
        output i_mul_rdy,
        output i_res_dat, i_res_ctl, i_res_err, i_res_val,
        input  o_res_rdy,
        input  o_rsp_dat, o_rsp_ctl, o_rsp_err, o_rsp_val,
        output i_rsp_rdy,
        input  o_tag_err
    );
endinterface

// File: rtl/mod_mult_arbiter.sv
// Round-robin sharing of one modular multiplier among NUM_CH clients: tagged
// requests go out through a one-entry register, responses route back by tag.
module mod_mult_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int DAT_BITS = 256,
    parameter int CTL_BITS = 16,
    parameter int MAX_OUT  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mod_mult_arbiter_if.slave bus
);
    localparam int TAG_BITS = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int CNT_BITS = $clog2(MAX_OUT + 1);
    localparam int MUL_CTL  = CTL_BITS + TAG_BITS;

    logic [TAG_BITS-1:0]   r_ptr;
    logic [CNT_BITS-1:0]   r_cnt [NUM_CH];
    logic                  r_out_val;
    logic [2*DAT_BITS-1:0] r_out_dat;
    logic [MUL_CTL-1:0]    r_out_ctl;
    logic                  r_out_err;
    logic                  r_tag_err;

    logic                  w_load;
    logic                  w_found;
    logic [TAG_BITS-1:0]   w_gnt;
    logic [TAG_BITS-1:0]   w_ptr_nxt;
    logic [NUM_CH-1:0]     w_elig;
    logic [NUM_CH-1:0]     w_req_rdy;
    logic [2*DAT_BITS-1:0] w_sel_dat;
    logic [CTL_BITS-1:0]   w_sel_ctl;
    logic                  w_sel_err;

    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_illegal;
    logic                  w_unexp;
    logic                  w_res_rdy;
    logic [NUM_CH-1:0]     w_rsp_val;
    logic [NUM_CH-1:0]     w_rsp_xfer;

    // The output register can take a new request when empty or draining this cycle.
    assign w_load = !r_out_val || bus.i_mul_rdy;

    always_comb begin
        w_elig = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_elig[k] = bus.i_req_val[k] && (r_cnt[k] < CNT_BITS'(MAX_OUT));
        end
    end

    // Offset i walks channels starting at r_ptr; the first eligible one wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_sel_dat = '0;
        w_sel_ctl = '0;
        w_sel_err = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_found && w_elig[k] && (((int'(r_ptr) + i) % NUM_CH) == k)) begin
                    w_found   = 1'b1;
                    w_gnt     = TAG_BITS'(k);
                    w_ptr_nxt = TAG_BITS'((k + 1) % NUM_CH);
                    w_sel_dat = bus.i_req_dat[k*2*DAT_BITS +: 2*DAT_BITS];
                    w_sel_ctl = bus.i_req_ctl[k*CTL_BITS +: CTL_BITS];
                    w_sel_err = bus.i_req_err[k];
                end
            end
        end
    end

    assign w_req_rdy = (!i_rst && w_load && w_found) ? (NUM_CH'(1) << w_gnt) : '0;

    assign w_tag = bus.i_res_ctl[MUL_CTL-1 -: TAG_BITS];

    // An out-of-range tag keeps w_illegal set and is swallowed with rdy high.
    always_comb begin
        w_rsp_val = '0;
        w_res_rdy = 1'b1;
        w_illegal = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_tag == TAG_BITS'(k)) begin
                w_illegal    = 1'b0;
                w_rsp_val[k] = bus.i_res_val;
                w_res_rdy    = bus.i_rsp_rdy[k];
            end
        end
        if (i_rst) begin
            w_rsp_val = '0;
            w_res_rdy = 1'b0;
        end
    end

    assign w_rsp_xfer = w_rsp_val & bus.i_rsp_rdy;

    always_comb begin
        w_unexp = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_rsp_xfer[k] && (r_cnt[k] == '0)) w_unexp = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_val <= 1'b0;
            r_ptr     <= '0;
            r_tag_err <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
        end else begin
            if (w_load) r_out_val <= w_found;
            if (w_load && w_found) r_ptr <= w_ptr_nxt;
            // A response with no matching request leaves the counter parked at zero.
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_req_rdy[k] && !w_rsp_xfer[k]) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end else if (!w_req_rdy[k] && w_rsp_xfer[k] && (r_cnt[k] != '0)) begin
                    r_cnt[k] <= r_cnt[k] - 1'b1;
                end
            end
            if ((bus.i_res_val && w_illegal) || w_unexp) r_tag_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_load && w_found) begin
            r_out_dat <= w_sel_dat;
            r_out_ctl <= {w_gnt, w_sel_ctl};
            r_out_err <= w_sel_err;
        end
    end

    assign bus.o_req_rdy = w_req_rdy;
    assign bus.o_mul_dat = r_out_dat;
    assign bus.o_mul_ctl = r_out_ctl;
    assign bus.o_mul_err = r_out_err;
    assign bus.o_mul_val = r_out_val;
    assign bus.o_res_rdy = w_res_rdy;
    assign bus.o_rsp_val = w_rsp_val;
    assign bus.o_rsp_dat = {NUM_CH{bus.i_res_dat}};
    assign bus.o_rsp_ctl = {NUM_CH{bus.i_res_ctl[CTL_BITS-1:0]}};
    assign bus.o_rsp_err = {NUM_CH{bus.i_res_err}};
    assign bus.o_tag_err = r_tag_err;
endmodule
